// File: rtl/sipo_pkg.sv
// Shared types and default K28.5 comma patterns for the serial-to-parallel aligner.
package sipo_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] K28_5_P = 10'b0011111010;
    localparam logic [9:0] K28_5_N = 10'b1100000101;

endpackage

// File: rtl/sipo_aligner_comma_detect.sv
// Combinational match of a W-bit window against either comma polarity.
module comma_detect
    import sipo_pkg::*;
#(
    parameter int             W       = 10,
    parameter logic [W-1:0]   COMMA_P = K28_5_P,
    parameter logic [W-1:0]   COMMA_N = K28_5_N
) (
    input  logic [W-1:0] window,
    output logic         match
);

    assign match = (window == COMMA_P) || (window == COMMA_N);

endmodule

// File: rtl/sipo_aligner.sv
// Serial-to-parallel converter with K28.5 comma alignment and symbol-lock tracking.
//   state  | meaning
//   HUNT   | no framing yet, waiting for any comma to set the word boundary
//   CHECK  | framing on boundary, counting aligned commas toward lock
//   LOCKED | symbol lock, tolerating off-boundary commas up to MISS_LIMIT
module sipo_aligner
    import sipo_pkg::*;
#(
    parameter int             W          = 10,
    parameter logic [W-1:0]   COMMA_P    = K28_5_P,
    parameter logic [W-1:0]   COMMA_N    = K28_5_N,
    parameter int             LOCK_COUNT = 3,
    parameter int             MISS_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         serial_in,
    input  logic         bit_en,
    input  logic         align_en,
    output logic [W-1:0] parallel_out,
    output logic         word_valid,
    output logic         is_comma,
    output logic         locked,
    output logic         align_err
);

    localparam int CW = $clog2(W);
    localparam int HW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    // Only W-1 history bits are needed; the incoming bit completes the window.
    logic [W-2:0]  sr;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hit_cnt;
    logic [MW-1:0] miss_cnt;
    state_t        state;

    logic [W-1:0]  nxt;
    logic          boundary;
    logic          comma;

    logic          emit;
    logic          err_nx;
    state_t        state_nx;
    logic [HW-1:0] hit_nx;
    logic [MW-1:0] miss_nx;
    logic [CW-1:0] cnt_nx;

    assign nxt      = {sr, serial_in};
    assign boundary = (cnt == CW'(W - 1));

    comma_detect #(
        .W       (W),
        .COMMA_P (COMMA_P),
        .COMMA_N (COMMA_N)
    ) u_comma_detect (
        .window (nxt),
        .match  (comma)
    );

    always_comb begin
        emit     = 1'b0;
        err_nx   = 1'b0;
        state_nx = state;
        hit_nx   = hit_cnt;
        miss_nx  = miss_cnt;
        if (!align_en) begin
            emit = boundary;
        end else begin
            case (state)
                HUNT: begin
                    if (comma) begin
                        emit     = 1'b1;
                        hit_nx   = HW'(1);
                        state_nx = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    if (comma && boundary) begin
                        emit   = 1'b1;
                        hit_nx = hit_cnt + HW'(1);
                        if (int'(hit_cnt) + 1 >= LOCK_COUNT)
                            state_nx = LOCKED;
                    end else if (comma) begin
                        emit   = 1'b1;
                        hit_nx = HW'(1);
                    end else if (boundary) begin
                        emit = 1'b1;
                    end
                end
                LOCKED: begin
                    if (comma && boundary) begin
                        emit    = 1'b1;
                        miss_nx = '0;
                    end else if (comma) begin
                        err_nx = 1'b1;
                        if (int'(miss_cnt) + 1 == MISS_LIMIT) begin
                            emit     = 1'b1;
                            miss_nx  = '0;
                            hit_nx   = HW'(1);
                            state_nx = CHECK;
                        end else begin
                            miss_nx = miss_cnt + MW'(1);
                        end
                    end else if (boundary) begin
                        emit = 1'b1;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
        // In HUNT the counter simply wraps so it never leaves 0..W-1.
        cnt_nx = (emit || boundary) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr           <= '0;
            cnt          <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            state        <= HUNT;
            parallel_out <= '0;
            word_valid   <= 1'b0;
            is_comma     <= 1'b0;
            locked       <= 1'b0;
            align_err    <= 1'b0;
        end else if (bit_en) begin
            sr         <= nxt[W-2:0];
            cnt        <= cnt_nx;
            word_valid <= emit;
            is_comma   <= emit && comma;
            align_err  <= err_nx;
            if (emit)
                parallel_out <= nxt;
            if (align_en) begin
                state    <= state_nx;
                hit_cnt  <= hit_nx;
                miss_cnt <= miss_nx;
                locked   <= (state_nx == LOCKED);
            end
        end else begin
            word_valid <= 1'b0;
            is_comma   <= 1'b0;
            align_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_aligner.sv
// Self-checking bench for sipo_aligner: behavioural framing model plus directed scenarios.
module tb_sipo_aligner;

    localparam int         W  = 10;
    localparam int         LC = 3;
    localparam int         ML = 2;
    localparam logic [9:0] CP = 10'h0FA;
    localparam logic [9:0] CN = 10'h305;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         serial_in = 1'b0;
    logic         bit_en = 1'b0;
    logic         align_en = 1'b1;
    logic [W-1:0] parallel_out;
    logic         word_valid;
    logic         is_comma;
    logic         locked;
    logic         align_err;

    int total = 0;
    int bad   = 0;

    sipo_aligner #(
        .W          (W),
        .COMMA_P    (CP),
        .COMMA_N    (CN),
        .LOCK_COUNT (LC),
        .MISS_LIMIT (ML)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .bit_en       (bit_en),
        .align_en     (align_en),
        .parallel_out (parallel_out),
        .word_valid   (word_valid),
        .is_comma     (is_comma),
        .locked       (locked),
        .align_err    (align_err)
    );

    always #5 clk = ~clk;

    // Reference: a window of the last W bits, bits since the last emitted word,
    // a phase name (0 hunting, 1 checking, 2 locked) and the two tallies.
    logic [W-1:0] m_win;
    int           m_since;
    int           m_phase;
    int           m_hits;
    int           m_miss;
    logic [W-1:0] m_word;
    logic         m_valid, m_comma, m_locked, m_err;

    logic bq[$];

    task automatic model_reset();
        m_win = '0; m_since = 0; m_phase = 0; m_hits = 0; m_miss = 0;
        m_word = '0; m_valid = 0; m_comma = 0; m_locked = 0; m_err = 0;
    endtask

    task automatic model_step(input logic b, input logic en, input logic aen);
        logic on_b, c, emit, err;
        if (!en) begin
            m_valid = 0; m_comma = 0; m_err = 0;
            return;
        end
        m_win = (m_win << 1) | W'(b);
        on_b  = (m_since == W - 1);
        c     = (m_win == CP) || (m_win == CN);
        emit  = 0;
        err   = 0;
        if (!aen) begin
            emit = on_b;
        end else if (m_phase == 0) begin
            if (c) begin emit = 1; m_hits = 1; m_phase = (LC == 1) ? 2 : 1; end
        end else if (m_phase == 1) begin
            if (c && on_b) begin
                emit = 1; m_hits = m_hits + 1;
                if (m_hits >= LC) m_phase = 2;
            end else if (c) begin
                emit = 1; m_hits = 1;
            end else if (on_b) emit = 1;
        end else begin
            if (c && on_b) begin
                emit = 1; m_miss = 0;
            end else if (c) begin
                err = 1; m_miss = m_miss + 1;
                if (m_miss == ML) begin emit = 1; m_miss = 0; m_hits = 1; m_phase = 1; end
            end else if (on_b) emit = 1;
        end
        m_since = emit ? 0 : (m_since + 1) % W;
        m_valid = emit;
        m_comma = emit && c;
        m_err   = err;
        if (emit) m_word = m_win;
        m_locked = (m_phase == 2);
    endtask

    task automatic drive(input logic b, input logic en, input logic aen);
        serial_in = b; bit_en = en; align_en = aen;
        @(posedge clk);
        #1;
        model_step(b, en, aen);
    endtask

    task automatic do_reset(input logic aen);
        rst = 1; bit_en = 0; serial_in = 0; align_en = aen;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) bq.push_back(w[i]);
    endfunction

    task automatic test_reset();
        rst = 1; bit_en = 1; serial_in = 1;
        @(posedge clk);
        #1;
        total++;
        if ({parallel_out, word_valid, is_comma, locked, align_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got w=%h v%b c%b l%b e%b, want all 0",
                     parallel_out, word_valid, is_comma, locked, align_err);
        end
        rst = 0; bit_en = 0;
        model_reset();
    endtask

    task automatic test_first_comma();
        do_reset(1);
        bq.delete();
        bq.push_back(1); bq.push_back(0); bq.push_back(1);
        push_word(CP);
        foreach (bq[i]) begin
            drive(bq[i], 1, 1);
            total++;
            if ({word_valid, is_comma, locked, align_err} !== {m_valid, m_comma, m_locked, m_err} || parallel_out !== m_word) begin
                bad++;
                $display("FAIL first_comma_model bit %0d: got v%b c%b l%b e%b w=%h, want v%b c%b l%b e%b w=%h",
                         i, word_valid, is_comma, locked, align_err, parallel_out, m_valid, m_comma, m_locked, m_err, m_word);
            end
        end
        total++;
        if (word_valid !== 1 || parallel_out !== 10'h0FA || is_comma !== 1 || locked !== 0) begin
            bad++;
            $display("FAIL first_comma_strobe: got v%b w=%h c%b l%b, want v1 w=0fa c1 l0",
                     word_valid, parallel_out, is_comma, locked);
        end
        drive(0, 0, 1);
        total++;
        if (word_valid !== 0 || parallel_out !== 10'h0FA) begin
            bad++;
            $display("FAIL first_comma_one_cycle: got v%b w=%h, want v0 w=0fa", word_valid, parallel_out);
        end
    endtask

    task automatic test_lock();
        int k;
        do_reset(1);
        bq.delete();
        bq.push_back(1); bq.push_back(0);
        push_word(CP); push_word(CN); push_word(CP);
        k = 0;
        foreach (bq[i]) begin
            drive(bq[i], 1, 1);
            total++;
            if ({word_valid, is_comma, locked, align_err} !== {m_valid, m_comma, m_locked, m_err} || parallel_out !== m_word) begin
                bad++;
                $display("FAIL lock_model bit %0d: got v%b c%b l%b e%b w=%h, want v%b c%b l%b e%b w=%h",
                         i, word_valid, is_comma, locked, align_err, parallel_out, m_valid, m_comma, m_locked, m_err, m_word);
            end
            if (word_valid === 1) begin
                k++;
                total++;
                if (locked !== (k == 3) || align_err !== 0) begin
                    bad++;
                    $display("FAIL lock_strobe %0d: got l%b e%b, want l%b e0", k, locked, align_err, (k == 3));
                end
            end
        end
        total++;
        if (k !== 3) begin
            bad++;
            $display("FAIL lock_strobe_count: got %0d, want 3", k);
        end
    endtask

    task automatic test_slip();
        for (int rep = 0; rep < 2; rep++) begin
            bq.delete();
            bq.push_back(0);
            push_word(CP);
            foreach (bq[i]) begin
                drive(bq[i], 1, 1);
                total++;
                if ({word_valid, is_comma, locked, align_err} !== {m_valid, m_comma, m_locked, m_err} || parallel_out !== m_word) begin
                    bad++;
                    $display("FAIL slip_model rep %0d bit %0d: got v%b c%b l%b e%b w=%h, want v%b c%b l%b e%b w=%h",
                             rep, i, word_valid, is_comma, locked, align_err, parallel_out, m_valid, m_comma, m_locked, m_err, m_word);
                end
            end
            total++;
            if (rep == 0 && (align_err !== 1 || word_valid !== 0 || locked !== 1)) begin
                bad++;
                $display("FAIL slip_first: got e%b v%b l%b, want e1 v0 l1", align_err, word_valid, locked);
            end else if (rep == 1 && (align_err !== 1 || word_valid !== 1 || parallel_out !== CP || locked !== 0)) begin
                bad++;
                $display("FAIL slip_realign: got e%b v%b w=%h l%b, want e1 v1 w=0fa l0",
                         align_err, word_valid, parallel_out, locked);
            end
        end
        bq.delete();
        push_word(CP); push_word(CP);
        foreach (bq[i]) drive(bq[i], 1, 1);
        total++;
        if (locked !== 1 || word_valid !== 1 || is_comma !== 1) begin
            bad++;
            $display("FAIL slip_relock: got l%b v%b c%b, want l1 v1 c1", locked, word_valid, is_comma);
        end
    endtask

    task automatic test_bit_en_random();
        logic [W:0] qa[$];
        logic [W:0] qb[$];
        logic [W-1:0] w;
        int guard;
        bq.delete();
        bq.push_back(1); bq.push_back(1);
        push_word(CP); push_word(CN); push_word(CP);
        for (int j = 0; j < 8; j++) begin
            w = W'($urandom_range(0, (1 << W) - 1));
            if (w == CP || w == CN) w = 10'h155;
            push_word(w);
            push_word((j % 2) ? CN : CP);
        end
        do_reset(1);
        foreach (bq[i]) begin
            drive(bq[i], 1, 1);
            total++;
            if ({word_valid, is_comma, locked, align_err} !== {m_valid, m_comma, m_locked, m_err} || parallel_out !== m_word) begin
                bad++;
                $display("FAIL cont_model bit %0d: got v%b c%b l%b e%b w=%h, want v%b c%b l%b e%b w=%h",
                         i, word_valid, is_comma, locked, align_err, parallel_out, m_valid, m_comma, m_locked, m_err, m_word);
            end
            if (m_valid) qa.push_back({m_locked, m_word});
        end
        do_reset(1);
        foreach (bq[i]) begin
            guard = 0;
            while ($urandom_range(0, 1) == 1 && guard < 8) begin
                drive(1'($urandom_range(0, 1)), 0, 1);
                guard++;
                total++;
                if (word_valid !== 0 || align_err !== 0) begin
                    bad++;
                    $display("FAIL gap_quiet bit %0d: got v%b e%b, want v0 e0", i, word_valid, align_err);
                end
            end
            drive(bq[i], 1, 1);
            if (word_valid === 1) qb.push_back({locked, parallel_out});
        end
        total++;
        if (qb.size() != qa.size()) begin
            bad++;
            $display("FAIL gap_word_count: got %0d, want %0d", qb.size(), qa.size());
        end else begin
            foreach (qa[i]) begin
                total++;
                if (qb[i] !== qa[i]) begin
                    bad++;
                    $display("FAIL gap_word %0d: got l%b w=%h, want l%b w=%h",
                             i, qb[i][W], qb[i][W-1:0], qa[i][W], qa[i][W-1:0]);
                end
            end
        end
    endtask

    task automatic test_free_run();
        do_reset(0);
        bq.delete();
        bq.push_back(1); bq.push_back(1); bq.push_back(0); bq.push_back(1);
        push_word(CP);
        push_word(10'h000);
        push_word(10'h000);
        foreach (bq[i]) begin
            drive(bq[i], 1, 0);
            total++;
            if ({word_valid, is_comma, locked, align_err} !== {m_valid, m_comma, m_locked, m_err} || parallel_out !== m_word) begin
                bad++;
                $display("FAIL free_model bit %0d: got v%b c%b l%b e%b w=%h, want v%b c%b l%b e%b w=%h",
                         i, word_valid, is_comma, locked, align_err, parallel_out, m_valid, m_comma, m_locked, m_err, m_word);
            end
            total++;
            if (word_valid !== ((i + 1) % W == 0) || is_comma !== 0 || locked !== 0) begin
                bad++;
                $display("FAIL free_strobe bit %0d: got v%b c%b l%b, want v%b c0 l0",
                         i, word_valid, is_comma, locked, ((i + 1) % W == 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        bq.delete();
        bq.push_back(1);
        push_word(CP); push_word(CP); push_word(CP);
        for (int j = 0; j < 5; j++) bq.push_back(1'($urandom_range(0, 1)));
        foreach (bq[i]) drive(bq[i], 1, 1);
        total++;
        if (locked !== 1) begin
            bad++;
            $display("FAIL midreset_prelock: got l%b, want l1", locked);
        end
        #2;
        rst = 1;
        #1;
        total++;
        if ({parallel_out, word_valid, is_comma, locked, align_err} !== '0) begin
            bad++;
            $display("FAIL midreset_async: got w=%h v%b c%b l%b e%b, want all 0",
                     parallel_out, word_valid, is_comma, locked, align_err);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        bq.delete();
        bq.push_back(0); bq.push_back(1); bq.push_back(1); bq.push_back(0);
        bq.push_back(1); bq.push_back(1); bq.push_back(1);
        push_word(CN);
        foreach (bq[i]) begin
            drive(bq[i], 1, 1);
            total++;
            if ({word_valid, is_comma, locked, align_err} !== {m_valid, m_comma, m_locked, m_err} || parallel_out !== m_word) begin
                bad++;
                $display("FAIL midreset_model bit %0d: got v%b c%b l%b e%b w=%h, want v%b c%b l%b e%b w=%h",
                         i, word_valid, is_comma, locked, align_err, parallel_out, m_valid, m_comma, m_locked, m_err, m_word);
            end
        end
        total++;
        if (word_valid !== 1 || parallel_out !== CN || is_comma !== 1 || locked !== 0) begin
            bad++;
            $display("FAIL midreset_refind: got v%b w=%h c%b l%b, want v1 w=305 c1 l0",
                     word_valid, parallel_out, is_comma, locked);
        end
    endtask

    initial begin
        model_reset();
        #3;
        test_reset();
        test_first_comma();
        test_lock();
        test_slip();
        test_bit_en_random();
        test_free_run();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_aligner.md
# sipo_aligner

Parametrised serial-to-parallel converter with comma-based word alignment for the PCIe physical-layer receiver. It shifts one received bit per enabled clock into a W-bit window and emits a framed parallel word with a one-cycle valid strobe. It hunts for the K28.5 comma, realigns the word boundary to it and reports symbol lock. It sits between the receive serial stream and the 8b/10b decoder, and adds framing, strobing and lock tracking over a plain shift register.

## Interface
Parameters:
- W, 10, word width in bits; must be ≥ 2.
- COMMA_P, 10'b0011111010, comma pattern (K28.5, RD−); W bits wide.
- COMMA_N, 10'b1100000101, comma pattern (K28.5, RD+); W bits wide.
- LOCK_COUNT, 3, consecutive boundary-aligned commas required to declare lock; ≥ 1.
- MISS_LIMIT, 2, consecutive off-boundary commas in LOCKED that force a realign; ≥ 1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- serial_in  in  1  received bit, first bit lands in the MSB of the word.
- bit_en  in  1  serial_in is valid this cycle; when low, no state changes.
- align_en  in  1  1 = comma alignment active; 0 = free-running framing every W bits.
- parallel_out  out  W  last emitted word, held between strobes.
- word_valid  out  1  one-cycle strobe: parallel_out updated this cycle.
- is_comma  out  1  emitted word matches COMMA_P or COMMA_N; qualified by word_valid.
- locked  out  1  high in state LOCKED.
- align_err  out  1  one-cycle pulse: off-boundary comma seen while LOCKED.

## Operation
- On bit_en=1: nxt = {sr[W-2:0], serial_in}; sr ← nxt. Bit counter cnt counts 0..W-1. boundary = (cnt == W-1). comma = nxt matches COMMA_P or COMMA_N.
- Emitting a word: parallel_out ← nxt, word_valid ← 1, is_comma ← comma, cnt ← 0. Otherwise cnt ← cnt+1 and word_valid ← 0.
- align_en=0: emit when boundary. Commas do not realign. The FSM and its counters are frozen.
- FSM (align_en=1), states HUNT, CHECK, LOCKED. The FSM also tracks hit_cnt and miss_cnt.
  - HUNT: no words emitted.
    - comma → realign and emit; hit_cnt ← 1; go to CHECK. If LOCK_COUNT=1, go to LOCKED instead.
  - CHECK: emit on boundary.
    - comma on boundary → hit_cnt+1; go to LOCKED when hit_cnt+1 = LOCK_COUNT.
    - comma off boundary → realign and emit; hit_cnt ← 1.
    - non-comma word on boundary → hit_cnt is unchanged.
  - LOCKED: emit on boundary.
    - comma on boundary → miss_cnt ← 0.
    - comma off boundary → align_err pulse; miss_cnt+1. No realign unless miss_cnt+1 = MISS_LIMIT. In that case: realign and emit, miss_cnt ← 0, hit_cnt ← 1, go to CHECK, locked falls.
- Realign means emit nxt immediately and set cnt ← 0, regardless of the current cnt.
- Simultaneous boundary and comma: treat as an on-boundary comma. There is never a double emit.
- Changing align_en from 1 to 0 mid-word keeps the current cnt phase.

## Timing
- All outputs are registered. word_valid, is_comma and align_err are asserted in the cycle after the clock edge that sampled the last bit of the word.
- Latency is 1 clock from the final bit's sampling edge to the word_valid cycle.
- The minimum spacing between strobes is 1 cycle, when a realign occurs right after an emit.
- bit_en low inserts wait cycles: no strobe and no counter change.
- Reset (asynchronous, any time including mid-word) sets:
  - parallel_out = 0, word_valid = 0, is_comma = 0, locked = 0, align_err = 0;
  - sr = 0, cnt = 0, hit_cnt = 0, miss_cnt = 0, state HUNT.
- After reset is released, the first sampled bit is bit 0 of the window.

## Structure
- Package sipo_pkg: state enum (HUNT, CHECK, LOCKED) and the default K28.5 constants.
- Sub-module comma_detect: combinational match of a W-bit window against COMMA_P/COMMA_N.
- The top level holds the shift register, counter, FSM and output registers.

## Test plan
- Reset, then 3 junk bits (1,0,1), then 0011111010 with bit_en=1 → word_valid exactly one cycle after the 10th comma bit; parallel_out=10'h0FA, is_comma=1, locked=0; state CHECK.
- Three back-to-back aligned commas (0FA, 305, 0FA) → locked rises with the third strobe; align_err stays 0.
- In LOCKED, slip one bit then send a comma → align_err pulse, no realign, locked=1. Repeat the slip immediately → realign strobe with parallel_out=comma, locked falls, state CHECK.
- In LOCKED, the same data stream with bit_en pseudo-random at 50% → identical word sequence and lock state to the continuous-bit_en run.
- align_en=0 from reset with a comma embedded at bit offset 4 → strobes every 10 enabled bits from reset; the comma is not aligned and is_comma=0 on all strobes.
- Assert rst for one cycle mid-word while LOCKED → all outputs 0 asynchronously, state HUNT; the next comma is found at any offset.
